// File: rtl/anton_neopixel_stream_pkg.sv
// Timing defaults, FSM encoding and buffer address stepping
// shared by the NeoPixel frame streamer.
package anton_neopixel_stream_pkg;

  localparam int BUFFER_END_DEFAULT     = 1023;
  localparam int NEO_BIT_CYCLES_DEFAULT = 25;
  localparam int NEO_T0H_DEFAULT        = 8;
  localparam int NEO_T1H_DEFAULT        = 16;
  localparam int NEO_RESET_DEFAULT      = 1000;
  localparam int IX_W                   = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_BITS  = 2'd2,
    ST_LATCH = 2'd3
  } neo_state_e;

  // In 32-bit mode byte 3 of every word is padding and skipped
  function automatic logic [IX_W-1:0] next_ix(
    input logic [IX_W-1:0] ix,
    input logic            mode32
  );
    if (mode32 && ix[1:0] == 2'd2)
      return ix + IX_W'(2);
    return ix + IX_W'(1);
  endfunction

endpackage

// File: rtl/anton_neopixel_bit_timer.sv
// Per-bit cycle counter and WS2812 high-time compare.
// The level is produced for the upcoming cycle so the output register adds no lag.
module anton_neopixel_bit_timer
  import anton_neopixel_stream_pkg::*;
#(
  parameter int BIT_CYCLES = NEO_BIT_CYCLES_DEFAULT,
  parameter int T0H_CYCLES = NEO_T0H_DEFAULT,
  parameter int T1H_CYCLES = NEO_T1H_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clear,
  input  logic bit_val,
  output logic bit_done,
  output logic level
);

  localparam int CW = $clog2(BIT_CYCLES + 1);

  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] thr;

  assign bit_done = en && cycle_cnt == CW'(BIT_CYCLES - 1);

  always_comb begin
    cnt_next = '0;
    if (en && !clear && !bit_done)
      cnt_next = cycle_cnt + CW'(1);
  end

  assign thr   = bit_val ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES);
  assign level = cnt_next < thr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cycle_cnt <= '0;
    else
      cycle_cnt <= cnt_next;
  end

endmodule

// File: rtl/anton_neopixel_stream.sv
// Walks the pixel buffer and serialises it as a WS2812 waveform.
// Define ANTON_NEOPIXEL_INVERT_EN to invert neoData (idle level 1).
module anton_neopixel_stream
  import anton_neopixel_stream_pkg::*;
#(
  parameter int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter int BIT_CYCLES   = NEO_BIT_CYCLES_DEFAULT,
  parameter int T0H_CYCLES   = NEO_T0H_DEFAULT,
  parameter int T1H_CYCLES   = NEO_T1H_DEFAULT,
  parameter int RESET_CYCLES = NEO_RESET_DEFAULT,
  localparam int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   busClk,
  input  logic                   busResetN,
  input  logic                   regCtrlRun,
  input  logic                   regCtrlInit,
  input  logic                   regCtrlLimit,
  input  logic                   regCtrl32bit,
  input  logic [12:0]            regMax,
  output logic [BUFFER_BITS-1:0] pixelIxComb,
  input  logic [7:0]             pixelByte,
  output logic                   streamSyncOf,
  output logic                   state,
  output logic                   neoData
);

  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam logic [IX_W-1:0] END_IX = IX_W'(BUFFER_END);
`ifdef ANTON_NEOPIXEL_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  if (!(T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_high
    $error("anton_neopixel_stream: need T0H < T1H < BIT_CYCLES");
  end
  if (BIT_CYCLES < 2 || RESET_CYCLES < 1) begin : g_bad_len
    $error("anton_neopixel_stream: BIT_CYCLES >= 2, RESET_CYCLES >= 1");
  end

  neo_state_e      fsm, fsm_n;
  logic [IX_W-1:0] cur_ix, cur_ix_n;
  logic [IX_W-1:0] last_ix, last_ix_n;
  logic [IX_W-1:0] nxt_ix, max_ix;
  logic [7:0]      shift, shift_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [LW-1:0]   latch_cnt, latch_cnt_n;
  logic            primed, primed_n;
  logic            mode32, mode32_n;
  logic            bit_done, level;

  assign nxt_ix = next_ix(cur_ix, mode32);
  assign max_ix = {1'b0, regMax};

  // Prefetch the following byte for the whole duration of the current one
  assign pixelIxComb = (fsm == ST_BITS) ? nxt_ix[BUFFER_BITS-1:0] : '0;

  anton_neopixel_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_timer (
    .clk      (busClk),
    .rst_n    (busResetN),
    .en       (fsm == ST_BITS),
    .clear    (regCtrlInit),
    .bit_val  (shift_n[7]),
    .bit_done (bit_done),
    .level    (level)
  );

  always_comb begin
    fsm_n       = fsm;
    cur_ix_n    = cur_ix;
    last_ix_n   = last_ix;
    shift_n     = shift;
    bit_cnt_n   = bit_cnt;
    latch_cnt_n = latch_cnt;
    primed_n    = primed;
    mode32_n    = mode32;
    if (regCtrlInit) begin
      fsm_n       = ST_IDLE;
      cur_ix_n    = '0;
      shift_n     = '0;
      bit_cnt_n   = '0;
      latch_cnt_n = '0;
      primed_n    = 1'b0;
    end else begin
      unique case (fsm)
        ST_IDLE: if (regCtrlRun) begin
          last_ix_n = (regCtrlLimit && max_ix < END_IX) ? max_ix : END_IX;
          mode32_n  = regCtrl32bit;
          primed_n  = 1'b0;
          fsm_n     = ST_PRIME;
        end
        ST_PRIME: begin
          primed_n = 1'b1;
          if (primed) begin
            shift_n   = pixelByte;
            cur_ix_n  = '0;
            bit_cnt_n = 3'd7;
            primed_n  = 1'b0;
            fsm_n     = ST_BITS;
          end
        end
        ST_BITS: if (bit_done) begin
          if (bit_cnt != 3'd0) begin
            shift_n   = {shift[6:0], 1'b0};
            bit_cnt_n = bit_cnt - 3'd1;
          end else if (nxt_ix > last_ix) begin
            fsm_n       = ST_LATCH;
            latch_cnt_n = '0;
          end else begin
            cur_ix_n  = nxt_ix;
            shift_n   = pixelByte;
            bit_cnt_n = 3'd7;
          end
        end
        ST_LATCH: begin
          if (latch_cnt == LW'(RESET_CYCLES - 1)) begin
            fsm_n       = ST_IDLE;
            latch_cnt_n = '0;
          end else begin
            latch_cnt_n = latch_cnt + LW'(1);
          end
        end
        default: fsm_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge busClk) begin
    if (!busResetN) begin
      fsm          <= ST_IDLE;
      cur_ix       <= '0;
      last_ix      <= '0;
      shift        <= '0;
      bit_cnt      <= '0;
      latch_cnt    <= '0;
      primed       <= 1'b0;
      mode32       <= 1'b0;
      neoData      <= INV;
      streamSyncOf <= 1'b0;
      state        <= 1'b0;
    end else begin
      fsm          <= fsm_n;
      cur_ix       <= cur_ix_n;
      last_ix      <= last_ix_n;
      shift        <= shift_n;
      bit_cnt      <= bit_cnt_n;
      latch_cnt    <= latch_cnt_n;
      primed       <= primed_n;
      mode32       <= mode32_n;
      neoData      <= INV ^ (fsm_n == ST_BITS && level);
      // Sync lands in the final latch cycle so IDLE sees the updated run bit
      streamSyncOf <= fsm_n == ST_LATCH &&
                      latch_cnt_n == LW'(RESET_CYCLES - 1);
      state        <= fsm_n != ST_IDLE;
    end
  end

endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Directed bench: a 3-byte buffer instance and a 256-byte instance
// share control inputs; waveforms are captured and decoded per bit.
module tb_anton_neopixel_stream;

  logic        busClk = 1'b0;
  logic        busResetN = 1'b0;
  logic        regCtrlRun = 1'b0;
  logic        regCtrlInit = 1'b0;
  logic        regCtrlLimit = 1'b0;
  logic        regCtrl32bit = 1'b0;
  logic [12:0] regMax = '0;

  logic [1:0] ix_s;
  logic [7:0] byte_s;
  logic       sync_s, state_s, data_s;
  logic [7:0] ix_l;
  logic [7:0] byte_l;
  logic       sync_l, state_l, data_l;

  logic [7:0] mem [0:255];
  bit         trace [0:51999];

  int n_vec = 0;
  int n_err = 0;
  int first_hi, sync_at, idle_at, sync_cnt;

  always #5 busClk = ~busClk;

  anton_neopixel_stream #(
    .BUFFER_END(2), .BIT_CYCLES(25), .T0H_CYCLES(8),
    .T1H_CYCLES(16), .RESET_CYCLES(40)
  ) dut_s (
    .busClk(busClk), .busResetN(busResetN),
    .regCtrlRun(regCtrlRun), .regCtrlInit(regCtrlInit),
    .regCtrlLimit(regCtrlLimit), .regCtrl32bit(regCtrl32bit),
    .regMax(regMax), .pixelIxComb(ix_s), .pixelByte(byte_s),
    .streamSyncOf(sync_s), .state(state_s), .neoData(data_s)
  );

  anton_neopixel_stream #(
    .BUFFER_END(255), .BIT_CYCLES(25), .T0H_CYCLES(8),
    .T1H_CYCLES(16), .RESET_CYCLES(40)
  ) dut_l (
    .busClk(busClk), .busResetN(busResetN),
    .regCtrlRun(regCtrlRun), .regCtrlInit(regCtrlInit),
    .regCtrlLimit(regCtrlLimit), .regCtrl32bit(regCtrl32bit),
    .regMax(regMax), .pixelIxComb(ix_l), .pixelByte(byte_l),
    .streamSyncOf(sync_l), .state(state_l), .neoData(data_l)
  );

  always @(posedge busClk) begin
    byte_s <= mem[ix_s];
    byte_l <= mem[ix_l];
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge busClk);
    #1;
  endtask

  task automatic quiesce();
    regCtrlRun  = 1'b0;
    regCtrlInit = 1'b1;
    step();
    regCtrlInit = 1'b0;
    step();
    chk("quiesce_idle", int'(state_s | state_l), 0);
  endtask

  function automatic int hi_time(input int b);
    int h = 0;
    int base = (first_hi < 0) ? 0 : first_hi;
    for (int j = 0; j < 25; j++)
      h += int'(trace[base + 25 * b + j]);
    return h;
  endfunction

  function automatic int get_byte(input int k);
    int v = 0;
    for (int b = 0; b < 8; b++)
      v = (v << 1) | int'(hi_time(8 * k + b) == 16);
    return v;
  endfunction

  // Index 0 of the trace is the cycle after the IDLE cycle that sees run
  task automatic frame(input bit sel, input bit keep,
                       input bit chg, input int budget);
    first_hi = -1;
    sync_at  = -1;
    idle_at  = -1;
    sync_cnt = 0;
    regCtrlRun = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      trace[i] = sel ? data_l : data_s;
      if (i == 0) begin
        regCtrlRun = keep;
        if (chg) begin
          regCtrlLimit = 1'b0;
          regCtrl32bit = 1'b0;
          regMax       = '0;
        end
      end
      if (first_hi < 0 && trace[i]) first_hi = i;
      if (sel ? sync_l : sync_s) begin
        sync_cnt++;
        sync_at = i;
      end
      if (sync_cnt > 0 && !(sel ? state_l : state_s)) begin
        idle_at = i;
        break;
      end
    end
    chk("frame_end", int'(idle_at >= 0), 1);
  endtask

  initial begin
    int a5_hi [8] = '{16, 8, 16, 8, 8, 16, 8, 16};
    int exp32 [6] = '{'hA5, 'hCA, 'hEF, 'h39, 'h5E, 'h83};
    int cnt;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 165);

    repeat (3) step();
    chk("rst_data_s", int'(data_s), 0);
    chk("rst_sync_s", int'(sync_s), 0);
    chk("rst_state_s", int'(state_s), 0);
    chk("rst_ix_s", int'(ix_s), 0);
    chk("rst_data_l", int'(data_l), 0);
    chk("rst_state_l", int'(state_l), 0);
    busResetN = 1'b1;
    step();
    chk("idle_no_run", int'(state_s), 0);

    // 3-byte buffer, no limit: A5 CA EF
    frame(1'b0, 1'b0, 1'b0, 800);
    chk("first_hi", first_hi, 2);
    for (int b = 0; b < 8; b++)
      chk($sformatf("a5_hi%0d", b), hi_time(b), a5_hi[b]);
    chk("byte1", get_byte(1), 'hCA);
    chk("byte2", get_byte(2), 'hEF);
    cnt = 0;
    for (int i = 602; i <= 641; i++) cnt += int'(trace[i]);
    chk("latch_low", cnt, 0);
    chk("sync_at", sync_at, 641);
    chk("sync_cnt", sync_cnt, 1);
    chk("idle_at", idle_at, 642);
    quiesce();

    // 32-bit stride, limit 7; settings changed once the frame starts
    regCtrlLimit = 1'b1;
    regCtrl32bit = 1'b1;
    regMax       = 13'd7;
    frame(1'b1, 1'b0, 1'b1, 1400);
    for (int k = 0; k < 6; k++)
      chk($sformatf("w32_byte%0d", k), get_byte(k), exp32[k]);
    chk("w32_sync_at", sync_at, 1241);
    quiesce();

    // Limit far beyond the buffer clamps to 256 bytes
    regCtrlLimit = 1'b1;
    regCtrl32bit = 1'b0;
    regMax       = 13'd5000;
    frame(1'b1, 1'b0, 1'b0, 52000);
    chk("clamp_b3", get_byte(3), 'h14);
    chk("clamp_b128", get_byte(128), 'h25);
    chk("clamp_b255", get_byte(255), 'h80);
    chk("clamp_sync_at", sync_at, 51241);
    quiesce();

    // Loop: run stays high across the sync
    regCtrlLimit = 1'b0;
    regMax       = '0;
    frame(1'b0, 1'b1, 1'b0, 800);
    chk("loop_sync_at", sync_at, 641);
    cnt = -1;
    for (int j = 0; j < 10; j++) begin
      step();
      if (j == 0) chk("loop_busy", int'(state_s), 1);
      if (data_s && cnt < 0) cnt = 643 + j - sync_at;
    end
    chk("loop_gap", cnt, 4);
    quiesce();

    // Abort mid-byte
    regCtrlRun = 1'b1;
    step();
    regCtrlRun = 1'b0;
    repeat (79) step();
    chk("pre_init_hi", int'(data_s), 1);
    regCtrlInit = 1'b1;
    step();
    regCtrlInit = 1'b0;
    chk("init_data", int'(data_s), 0);
    chk("init_state", int'(state_s), 0);
    cnt = 0;
    for (int j = 0; j < 700; j++) begin
      step();
      cnt += int'(sync_s) + int'(data_s) + int'(state_s);
    end
    chk("init_quiet", cnt, 0);

    // Reset during LATCH with run held, then restart from address 0
    regCtrlRun = 1'b1;
    step();
    regCtrlRun = 1'b0;
    repeat (612) step();
    chk("in_latch", int'(state_s), 1);
    regCtrlRun = 1'b1;
    busResetN  = 1'b0;
    step();
    chk("rst2_data", int'(data_s), 0);
    chk("rst2_sync", int'(sync_s), 0);
    chk("rst2_state", int'(state_s), 0);
    chk("rst2_ix", int'(ix_s), 0);
    repeat (2) step();
    busResetN = 1'b1;
    frame(1'b0, 1'b0, 1'b0, 800);
    chk("restart_first_hi", first_hi, 2);
    chk("restart_byte0", get_byte(0), 'hA5);
    chk("restart_sync_at", sync_at, 641);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_stream.md
# anton_neopixel_stream

Frame streamer directly downstream of the NeoPixel register/frame-buffer block. It walks the raw pixel buffer through the block's combinational read port (`pixelIxComb` → `pixelByte`, one-cycle RAM latency) and serialises each byte MSB-first into the WS2812 one-wire waveform. It then holds the line low for the latch/reset period and pulses `streamSyncOf` so the register block can clear or retain `regCtrlRun` according to loop mode.

## Interface
- `BUFFER_END`, `` `BUFFER_END_DEFAULT ``: last valid raw-buffer byte index.
- `BUFFER_BITS`, `` `CLOG2(BUFFER_END+1) ``: localparam, address width.
- `BIT_CYCLES`, 25: clocks per data bit (1.25 µs at 20 MHz).
- `T0H_CYCLES`, 8: high time of a 0 bit.
- `T1H_CYCLES`, 16: high time of a 1 bit.
- `RESET_CYCLES`, 1000: low time after frame (50 µs at 20 MHz).

Ports:
- `busClk`  in  1  the only clock.
- `busResetN`  in  1  synchronous, active-low reset.
- `regCtrlRun`  in  1  start/continue streaming.
- `regCtrlInit`  in  1  abort request.
- `regCtrlLimit`  in  1  use `regMax` as the frame end.
- `regCtrl32bit`  in  1  4-byte pixel stride; byte 3 is skipped.
- `regMax`  in  13  last byte index when limited.
- `pixelIxComb`  out  BUFFER_BITS  read address to the buffer RAM.
- `pixelByte`  in  8  RAM data, valid one cycle after the address.
- `streamSyncOf`  out  1  one-cycle pulse at the end of the reset period.
- `state`  out  1  1 = busy (not IDLE).
- `neoData`  out  1  serial line.

## Operation
- FSM: IDLE, PRIME, BITS, LATCH.
- IDLE:
  - `neoData`=0, `pixelIxComb`=0.
  - If `regCtrlRun` && !`regCtrlInit`: latch `lastIx` and `mode32`, then go to PRIME.
  - `lastIx` = `regCtrlLimit` ? min(`regMax`, BUFFER_END) : BUFFER_END, compared at 14 bits.
- PRIME: exactly 2 cycles, with address 0 presented. On the 2nd cycle load the shift register from `pixelByte`, set `curIx`=0 and `bitCnt`=7, then go to BITS.
- BITS:
  - `cycleCnt` runs 0..BIT_CYCLES-1.
  - `neoData` = `cycleCnt` < (`shift[7]` ? T1H_CYCLES : T0H_CYCLES).
  - `pixelIxComb` = `nextIx(curIx)` for the whole byte.
- `nextIx(i)`: in 32-bit mode, i+2 if i[1:0]==2, otherwise i+1.
- End of bit (`cycleCnt`==BIT_CYCLES-1):
  - If `bitCnt`≠0: shift left and decrement `bitCnt`.
  - Else, if `nextIx(curIx)` > `lastIx`: go to LATCH.
  - Else: `curIx` ← `nextIx`, shift ← `pixelByte`, `bitCnt` ← 7. The waveform has no inter-byte gap.
- LATCH:
  - `neoData`=0 for RESET_CYCLES.
  - On the last cycle assert `streamSyncOf` for 1 cycle, then go to IDLE.
- `regCtrlRun` falling mid-frame: the frame completes normally.
- `regCtrlInit`=1 in any state: go to IDLE the next cycle. `neoData`=0, counters cleared, no `streamSyncOf`.
- Loop: the register block updates `regCtrlRun` on the `streamSyncOf` edge, so IDLE sees the post-sync value. Looping costs exactly 1 IDLE cycle between frames.
- Limit/32-bit settings are sampled only at IDLE→PRIME; later changes do not affect the current frame.

## Timing
- Reset values: FSM=IDLE, `neoData`=0, `streamSyncOf`=0, `state`=0, `pixelIxComb`=0, all counters 0.
- `neoData`, `streamSyncOf` and `state` are registered.
- `pixelIxComb` is combinational from `curIx`/FSM.
- First rising edge of `neoData`: 3 cycles after the first cycle `regCtrlRun` is sampled high (IDLE, PRIME, PRIME).
- Frame length: 3 + 8·BIT_CYCLES·N + RESET_CYCLES cycles, where N = transmitted bytes.
- `pixelByte` is needed only at the byte boundary, ≥8·BIT_CYCLES−1 cycles after its address was set.
- Elaboration-time checks:
  - T0H_CYCLES < T1H_CYCLES < BIT_CYCLES.
  - BIT_CYCLES ≥ 2.
- Reset mid-operation: synchronous return to IDLE with all outputs at reset values.

## Configuration
- `ANTON_NEOPIXEL_INVERT_EN`:
  - Defined: `neoData` is inverted at the output register for inverting level shifters. The idle/reset level is 1; the same register stage is used, so latency is unchanged.
  - Undefined: `neoData` has normal polarity.

## Structure
- The `anton_common.vh` header holds:
  - Timing defaults `NEO_BIT_CYCLES_DEFAULT`, `NEO_T0H_DEFAULT`, `NEO_T1H_DEFAULT`, `NEO_RESET_DEFAULT`.
  - FSM state encodings.
  - Existing `CLOG2`/`BUFFER_END_DEFAULT`.
- Sub-module `anton_neopixel_bit_timer`: owns `cycleCnt` and the high-time compare. It emits `bitDone` and the raw level.

## Test plan
- Bench uses BIT_CYCLES=25, T0H=8, T1H=16, RESET_CYCLES=40.
- Byte 0 = 0xA5, run, no limit, BUFFER_END=2 → 24 bits. High times: 16,8,16,8,8,16,8,16 for the first byte. Then 40 low cycles and one `streamSyncOf` pulse; `state` returns to 0.
- 32-bit mode, limit, `regMax`=7 → addresses 0,1,2,4,5,6 in order. Bytes 3 and 7 are never sent; 48 bits total.
- Limit with `regMax`=5000 and BUFFER_END=255 → clamps to 256 bytes.
- Loop: `regCtrlRun` held by the model on sync → next frame's first high edge occurs exactly 4 cycles after the `streamSyncOf` cycle.
- `regCtrlInit` pulsed mid-byte → next cycle `neoData`=0 and `state`=0; no `streamSyncOf` is seen.
- `busResetN`=0 during LATCH → all outputs 0 next cycle. Run is held during reset; after release the frame restarts from address 0.
